// File: rtl/tim_apb_pkg.sv
// Shared types and constants for the timer APB initiator and its users.
// Register offsets are shared with the self-test sequencer and the harness.
package tim_apb_pkg;

  localparam int TIM_ADDR_W = 12;
  localparam int TIM_DATA_W = 32;

  localparam logic [TIM_ADDR_W-1:0] TIM_REG_CTRL  = 12'h000;
  localparam logic [TIM_ADDR_W-1:0] TIM_REG_LOAD  = 12'h004;
  localparam logic [TIM_ADDR_W-1:0] TIM_REG_COUNT = 12'h008;
  localparam logic [TIM_ADDR_W-1:0] TIM_REG_IRQ   = 12'h00C;
  localparam logic [TIM_ADDR_W-1:0] TIM_REG_PRESC = 12'h010;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2
  } apb_state_e;

  // Wait counter width; a disabled timeout still gets a 1-bit counter.
  function automatic int wdog_cnt_w(input int limit);
    return (limit > 0) ? $clog2(limit + 1) : 1;
  endfunction

endpackage

// File: rtl/tim_apb_if.sv
// APB3/APB4 signal bundle between the timer initiator and the timer slave port.
interface tim_apb_if #(
  parameter int ADDR_W = tim_apb_pkg::TIM_ADDR_W,
  parameter int DATA_W = tim_apb_pkg::TIM_DATA_W
);
  localparam int STRB_W = DATA_W / 8;

  logic              psel;
  logic              penable;
  logic              pwrite;
  logic [ADDR_W-1:0] paddr;
  logic [DATA_W-1:0] pwdata;
  logic [STRB_W-1:0] pstrb;
  logic              pready;
  logic              pslverr;
  logic [DATA_W-1:0] prdata;

  modport master (
    output psel, penable, pwrite, paddr, pwdata, pstrb,
    input  pready, pslverr, prdata
  );

  modport slave (
    input  psel, penable, pwrite, paddr, pwdata, pstrb,
    output pready, pslverr, prdata
  );

endinterface

// File: rtl/tim_apb_wdog.sv
// Saturating ACCESS wait-state counter; flags the last allowed wait cycle.
module tim_apb_wdog
  import tim_apb_pkg::*;
#(
  parameter int TIMEOUT_CYC = 255
) (
  input  logic sys_clk,
  input  logic sys_rst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int CNT_W = wdog_cnt_w(TIMEOUT_CYC);
  localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(TIMEOUT_CYC);
  localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT_CYC > 0) ? CNT_W'(TIMEOUT_CYC - 1) : '0;

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge sys_clk) begin
    if (sys_rst || clr) begin
      cnt <= '0;
    end else if (en && (cnt != CNT_SAT)) begin
      cnt <= cnt + 1'b1;
    end
  end

  // Asserted in the wait cycle whose increment would reach the limit, so the
  // abort lands after exactly TIMEOUT_CYC ACCESS cycles.
  assign expired = (TIMEOUT_CYC > 0) && en && (cnt == CNT_LAST);

endmodule

// File: rtl/tim_apb_master.sv
// Single-beat valid/ready command port to APB initiator for the timer block,
// with a wait-state timeout so a hung slave cannot stall the requester.
//
// state  | meaning
// IDLE   | cmd_ready high, APB outputs zero, waiting for a command
// SETUP  | psel high, penable low, command latched onto the bus
// ACCESS | psel and penable high, waiting for pready or the timeout
module tim_apb_master
  import tim_apb_pkg::*;
#(
  parameter int ADDR_W      = TIM_ADDR_W,
  parameter int DATA_W      = TIM_DATA_W,
  parameter int TIMEOUT_CYC = 255,
  localparam int STRB_W     = DATA_W / 8
) (
  input  logic              sys_clk,
  input  logic              sys_rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  input  logic [STRB_W-1:0] cmd_strb,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              rsp_timeout,
  tim_apb_if.master         tim
);

  apb_state_e state, state_nxt;
  logic       hs;
  logic       done;
  logic       abort;
  logic       wd_expired;

  assign hs = cmd_valid & cmd_ready;

  tim_apb_wdog #(
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_wdog (
    .sys_clk (sys_clk),
    .sys_rst (sys_rst),
    .clr     (hs),
    .en      ((state == ST_ACCESS) && !tim.pready),
    .expired (wd_expired)
  );

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // pready is only looked at in ACCESS; completion takes priority over timeout.
  always_comb begin
    state_nxt = state;
    done      = 1'b0;
    abort     = 1'b0;
    case (state)
      ST_IDLE: begin
        if (hs) begin
          state_nxt = ST_SETUP;
        end
      end
      ST_SETUP: begin
        state_nxt = ST_ACCESS;
      end
      ST_ACCESS: begin
        if (tim.pready) begin
          done      = 1'b1;
          state_nxt = ST_IDLE;
        end else if (wd_expired) begin
          abort     = 1'b1;
          state_nxt = ST_IDLE;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // The APB address/data registers double as the command latches.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      cmd_ready   <= 1'b1;
      tim.psel    <= 1'b0;
      tim.penable <= 1'b0;
      tim.pwrite  <= 1'b0;
      tim.paddr   <= '0;
      tim.pwdata  <= '0;
      tim.pstrb   <= '0;
    end else begin
      cmd_ready   <= (state_nxt == ST_IDLE);
      tim.psel    <= (state_nxt != ST_IDLE);
      tim.penable <= (state_nxt == ST_ACCESS);
      if (hs) begin
        tim.pwrite <= cmd_write;
        tim.paddr  <= cmd_addr;
        tim.pwdata <= cmd_wdata;
        tim.pstrb  <= cmd_write ? cmd_strb : '0;
      end else if (state_nxt == ST_IDLE) begin
        tim.pwrite <= 1'b0;
        tim.paddr  <= '0;
        tim.pwdata <= '0;
        tim.pstrb  <= '0;
      end
    end
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      rsp_valid   <= 1'b0;
      rsp_rdata   <= '0;
      rsp_err     <= 1'b0;
      rsp_timeout <= 1'b0;
    end else begin
      rsp_valid <= done | abort;
      if (done) begin
        rsp_rdata   <= tim.pwrite ? '0 : tim.prdata;
        rsp_err     <= tim.pslverr;
        rsp_timeout <= 1'b0;
      end else if (abort) begin
        rsp_rdata   <= '0;
        rsp_err     <= 1'b1;
        rsp_timeout <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_tim_apb_master.sv
// Bench for tim_apb_master: vector table plus directed timing, reset and
// back-to-back sequences; responses are checked against a queued scoreboard.
module tb_tim_apb_master;
  import tim_apb_pkg::*;

  localparam int AW = 12;
  localparam int DW = 32;
  localparam int SW = 4;
  localparam int TO = 4;
  localparam int NV = 8;

  typedef struct {
    logic          write;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [SW-1:0] strb;
    int            waits;
    logic [DW-1:0] prdata;
    logic          slverr;
    logic          early;
    logic          hang;
    logic [DW-1:0] exp_rdata;
    logic          exp_err;
    logic          exp_to;
    int            exp_lat;
  } vec_t;

  typedef struct {
    logic [DW-1:0] rdata;
    logic          err;
    logic          to;
    int            hs_cyc;
    int            lat;
  } exp_t;

  logic          sys_clk = 1'b0;
  logic          sys_rst = 1'b1;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic          cmd_write = 1'b0;
  logic [AW-1:0] cmd_addr = '0;
  logic [DW-1:0] cmd_wdata = '0;
  logic [SW-1:0] cmd_strb = '0;
  logic          rsp_valid;
  logic [DW-1:0] rsp_rdata;
  logic          rsp_err;
  logic          rsp_timeout;

  tim_apb_if #(.ADDR_W(AW), .DATA_W(DW)) tim ();

  tim_apb_master #(
    .ADDR_W      (AW),
    .DATA_W      (DW),
    .TIMEOUT_CYC (TO)
  ) dut (
    .sys_clk     (sys_clk),
    .sys_rst     (sys_rst),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_write   (cmd_write),
    .cmd_addr    (cmd_addr),
    .cmd_wdata   (cmd_wdata),
    .cmd_strb    (cmd_strb),
    .rsp_valid   (rsp_valid),
    .rsp_rdata   (rsp_rdata),
    .rsp_err     (rsp_err),
    .rsp_timeout (rsp_timeout),
    .tim         (tim)
  );

  int n_total = 0;
  int n_bad = 0;
  int cyc = 0;
  int last_hs = 0;
  int n_rsp = 0;
  int pen_run = 0;
  int last_pen_run = 0;
  bit mon_en = 1'b0;
  bit prev_rv = 1'b0;
  exp_t exp_q[$];

  logic          cur_write = 1'b0;
  logic [AW-1:0] cur_addr = '0;
  logic [DW-1:0] cur_wdata = '0;
  logic [SW-1:0] cur_strb = '0;
  logic [DW-1:0] last_rdata = '0;
  logic          last_err = 1'b0;
  logic          last_to = 1'b0;

  int            slv_waits = 0;
  logic [DW-1:0] slv_prdata = '0;
  logic          slv_err = 1'b0;
  logic          slv_early = 1'b0;
  logic          slv_hang = 1'b0;
  logic          slv_addr_mode = 1'b0;
  int            acc_cnt = 0;

  vec_t vecs[NV];

  always #5 sys_clk = ~sys_clk;

  initial forever begin
    @(posedge sys_clk);
    cyc++;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Slave model: pready after `waits` extra ACCESS cycles; optional early
  // pready/pslverr during SETUP that the initiator must ignore.
  initial begin
    tim.pready  = 1'b0;
    tim.pslverr = 1'b0;
    tim.prdata  = '0;
    forever begin
      @(negedge sys_clk);
      if (tim.psel && tim.penable) begin
        tim.pready  = !slv_hang && (acc_cnt >= slv_waits);
        tim.pslverr = slv_err;
        acc_cnt++;
      end else begin
        tim.pready  = tim.psel && slv_early;
        tim.pslverr = slv_early;
        acc_cnt = 0;
      end
      if (tim.pready && tim.penable)
        tim.prdata = slv_addr_mode ? (32'hA5A5_0000 | 32'(tim.paddr)) : slv_prdata;
      else
        tim.prdata = $urandom();
    end
  end

  // Bus stability, penable run length and response scoreboard.
  initial forever begin
    exp_t e;
    @(negedge sys_clk);
    if (mon_en) begin
      if (tim.psel)
        chk("bus_hold", {tim.pwrite, tim.paddr, tim.pwdata, tim.pstrb},
            {cur_write, cur_addr, cur_wdata, cur_strb});
      else
        chk("bus_idle", {tim.penable, tim.pwrite, tim.paddr, tim.pwdata, tim.pstrb}, 64'd0);
      if (tim.penable) begin
        pen_run++;
      end else if (pen_run != 0) begin
        last_pen_run = pen_run;
        pen_run = 0;
      end
      if (rsp_valid) begin
        chk("rsp_one_cycle", 64'(prev_rv), 64'd0);
        if (exp_q.size() == 0) begin
          n_total++;
          n_bad++;
          $display("FAIL rsp_unexpected: got rsp_valid=1 at cycle %0d, want no response", cyc);
        end else begin
          e = exp_q.pop_front();
          chk("rsp_rdata", 64'(rsp_rdata), 64'(e.rdata));
          chk("rsp_err", 64'(rsp_err), 64'(e.err));
          chk("rsp_timeout", 64'(rsp_timeout), 64'(e.to));
          chk("rsp_latency", 64'(cyc - e.hs_cyc), 64'(e.lat));
          last_rdata = e.rdata;
          last_err   = e.err;
          last_to    = e.to;
          n_rsp++;
        end
      end else begin
        chk("rsp_hold", {rsp_rdata, rsp_err, rsp_timeout}, {last_rdata, last_err, last_to});
      end
      prev_rv = rsp_valid;
    end
  end

  task automatic set_slave(input vec_t v);
    slv_waits     = v.waits;
    slv_prdata    = v.prdata;
    slv_err       = v.slverr;
    slv_early     = v.early;
    slv_hang      = v.hang;
    slv_addr_mode = 1'b0;
  endtask

  // Called just after a rising edge; returns just after the edge that follows
  // the handshake, with cmd_valid still high.
  task automatic issue(input vec_t v);
    bit   got;
    exp_t e;
    got = 1'b0;
    cmd_valid = 1'b1;
    cmd_write = v.write;
    cmd_addr  = v.addr;
    cmd_wdata = v.wdata;
    cmd_strb  = v.strb;
    for (int n = 0; n < 40 && !got; n++) begin
      @(negedge sys_clk);
      if (cmd_ready) got = 1'b1;
    end
    if (!got) begin
      n_total++;
      n_bad++;
      $display("FAIL cmd_handshake: got cmd_ready=0 for 40 cycles, want acceptance");
    end else begin
      e.rdata  = v.exp_rdata;
      e.err    = v.exp_err;
      e.to     = v.exp_to;
      e.hs_cyc = cyc;
      e.lat    = v.exp_lat;
      exp_q.push_back(e);
      cur_write = v.write;
      cur_addr  = v.addr;
      cur_wdata = v.wdata;
      cur_strb  = v.write ? v.strb : '0;
      last_hs   = cyc;
    end
    @(posedge sys_clk);
    #1;
  endtask

  task automatic idle_cmd();
    cmd_valid = 1'b0;
    cmd_write = 1'($urandom());
    cmd_addr  = AW'($urandom());
    cmd_wdata = $urandom();
    cmd_strb  = SW'($urandom());
  endtask

  task automatic drain();
    bit ok;
    ok = 1'b0;
    for (int n = 0; n < 60; n++) begin
      if (exp_q.size() == 0) begin
        ok = 1'b1;
        break;
      end
      @(negedge sys_clk);
    end
    if (!ok) begin
      n_total++;
      n_bad++;
      $display("FAIL rsp_missing: got %0d responses outstanding after 60 cycles, want 0", exp_q.size());
      exp_q.delete();
    end
    @(posedge sys_clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got simulation still running at %0t, want completion", $time);
    $fatal(1, "bench watchdog expired");
  end

  initial begin
    vec_t v;
    int   prev;
    int   first;

    //           wr    addr           wdata          strb  wt prdata         err  erl  hng  exp_rdata      eerr eto lat
    vecs[0] = '{1'b1, TIM_REG_LOAD,  32'hDEADBEEF, 4'hF, 0, 32'h0,         1'b0,1'b0,1'b0, 32'h0,         1'b0,1'b0,3};
    vecs[1] = '{1'b0, TIM_REG_COUNT, 32'h5555AAAA, 4'hF, 3, 32'h12345678,  1'b0,1'b0,1'b0, 32'h12345678,  1'b0,1'b0,6};
    vecs[2] = '{1'b1, TIM_REG_IRQ,   32'h00000011, 4'h3, 1, 32'h0,         1'b1,1'b1,1'b0, 32'h0,         1'b1,1'b0,4};
    vecs[3] = '{1'b0, TIM_REG_CTRL,  32'h0,        4'h0, 0, 32'hCAFEF00D,  1'b1,1'b0,1'b0, 32'hCAFEF00D,  1'b1,1'b0,3};
    vecs[4] = '{1'b0, TIM_REG_PRESC, 32'h0,        4'hF, 0, 32'h77777777,  1'b0,1'b0,1'b1, 32'h0,         1'b1,1'b1,6};
    vecs[5] = '{1'b1, TIM_REG_LOAD,  32'h01020304, 4'h5, 0, 32'h0,         1'b0,1'b0,1'b1, 32'h0,         1'b1,1'b1,6};
    vecs[6] = '{1'b0, TIM_REG_COUNT, 32'hFFFFFFFF, 4'hF, 2, 32'h0000FFFF,  1'b0,1'b1,1'b0, 32'h0000FFFF,  1'b0,1'b0,5};
    vecs[7] = '{1'b1, 12'hFFC,       32'hA5A5A5A5, 4'h8, 3, 32'h0,         1'b0,1'b0,1'b0, 32'h0,         1'b0,1'b0,6};

    repeat (3) @(posedge sys_clk);
    @(negedge sys_clk);
    chk("reset_apb", {tim.psel, tim.penable, tim.pwrite, tim.paddr, tim.pstrb}, 64'd0);
    chk("reset_pwdata", 64'(tim.pwdata), 64'd0);
    chk("reset_cmd_rsp", {cmd_ready, rsp_valid, rsp_err, rsp_timeout}, 64'b1000);
    chk("reset_rdata", 64'(rsp_rdata), 64'd0);
    @(posedge sys_clk);
    #1;
    sys_rst = 1'b0;
    mon_en  = 1'b1;

    // Zero-wait write with cycle-by-cycle phase checks.
    set_slave(vecs[0]);
    issue(vecs[0]);
    idle_cmd();
    @(negedge sys_clk);
    chk("t1_setup", {tim.psel, tim.penable, cmd_ready}, 64'b100);
    @(negedge sys_clk);
    chk("t1_access", {tim.psel, tim.penable, cmd_ready}, 64'b110);
    @(negedge sys_clk);
    chk("t1_resp", {tim.psel, tim.penable, cmd_ready, rsp_valid}, 64'b0011);
    drain();
    chk("t1_pen_cycles", 64'(last_pen_run), 64'd1);

    // Error write, then a read accepted in the response cycle.
    v = '{1'b1, TIM_REG_IRQ, 32'h0000_00FF, 4'hF, 0, 32'h600DCAFE, 1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 3};
    set_slave(v);
    issue(v);
    prev = last_hs;
    v = '{1'b0, TIM_REG_CTRL, 32'h0, 4'hF, 0, 32'h600DCAFE, 1'b1, 1'b0, 1'b0, 32'h600DCAFE, 1'b1, 1'b0, 3};
    issue(v);
    chk("accept_at_rsp", 64'(last_hs - prev), 64'd3);
    idle_cmd();
    drain();

    for (int i = 1; i < NV; i++) begin
      set_slave(vecs[i]);
      issue(vecs[i]);
      idle_cmd();
      drain();
      chk("pen_cycles", 64'(last_pen_run), vecs[i].hang ? 64'(TO) : 64'(vecs[i].waits + 1));
    end

    // Reset pulse during ACCESS against a hung slave.
    v = '{1'b0, TIM_REG_IRQ, 32'h0, 4'hF, 0, 32'h0, 1'b0, 1'b0, 1'b1, 32'h0, 1'b0, 1'b0, 3};
    set_slave(v);
    issue(v);
    idle_cmd();
    @(negedge sys_clk);
    @(posedge sys_clk);
    #1;
    sys_rst = 1'b1;
    exp_q.delete();
    @(posedge sys_clk);
    #1;
    last_rdata = '0;
    last_err   = 1'b0;
    last_to    = 1'b0;
    @(negedge sys_clk);
    chk("rst_mid_apb", {tim.psel, tim.penable, tim.pwrite, tim.paddr, tim.pstrb}, 64'd0);
    chk("rst_mid_pwdata", 64'(tim.pwdata), 64'd0);
    chk("rst_mid_cmd", {cmd_ready, rsp_valid}, 64'b10);
    @(posedge sys_clk);
    #1;
    sys_rst = 1'b0;
    repeat (4) @(posedge sys_clk);
    #1;
    v = '{1'b0, TIM_REG_CTRL, 32'h0, 4'hF, 0, 32'h0BADF00D, 1'b0, 1'b0, 1'b0, 32'h0BADF00D, 1'b0, 1'b0, 3};
    set_slave(v);
    issue(v);
    idle_cmd();
    drain();

    // Back-to-back with cmd_valid held; read data encodes the address.
    slv_waits = 0; slv_err = 1'b0; slv_early = 1'b0; slv_hang = 1'b0; slv_addr_mode = 1'b1;
    first = n_rsp;
    for (int i = 0; i < 8; i++) begin
      v.write     = (i % 2) == 1;
      v.addr      = 12'h100 + 12'(i * 4);
      v.wdata     = $urandom();
      v.strb      = SW'(i + 1);
      v.exp_rdata = v.write ? 32'h0 : (32'hA5A5_0000 | 32'(v.addr));
      v.exp_err   = 1'b0;
      v.exp_to    = 1'b0;
      v.exp_lat   = 3;
      prev = last_hs;
      issue(v);
      if (i > 0) chk("b2b_gap", 64'(last_hs - prev), 64'd3);
    end
    idle_cmd();
    drain();
    chk("b2b_rsp_count", 64'(n_rsp - first), 64'd8);

    repeat (3) @(posedge sys_clk);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/tim_apb_master.md
# tim_apb_master

APB initiator for the timer subsystem. It turns single-beat commands from a simple valid/ready request port into APB3/APB4 transfers. It drives the same APB signal set that the timer's APB slave port receives (psel, penable, pwrite, paddr, pwdata, pstrb; pready, prdata, pslverr). It serves as the register-access engine for self-test logic and for the verification harness, and adds a wait-state timeout so a hung slave cannot stall the initiator.

## Interface
Parameters:
- ADDR_W, 12, APB address width (matches timer register map)
- DATA_W, 32, APB data width; STRB_W = DATA_W/8
- TIMEOUT_CYC, 255, max ACCESS cycles with pready low before abort; 0 disables timeout

Ports:
- sys_clk  in  1  single clock; all logic on rising edge
- sys_rst  in  1  synchronous, active-high reset
- cmd_valid  in  1  command request
- cmd_ready  out  1  command accepted when cmd_valid & cmd_ready
- cmd_write  in  1  1 = write, 0 = read
- cmd_addr  in  ADDR_W  target address
- cmd_wdata  in  DATA_W  write data
- cmd_strb  in  STRB_W  byte strobes (forced to 0 on reads)
- rsp_valid  out  1  one-cycle response pulse
- rsp_rdata  out  DATA_W  read data (0 for writes and timeouts)
- rsp_err  out  1  pslverr sampled, or timeout
- rsp_timeout  out  1  abort due to timeout
- tim_psel, tim_penable, tim_pwrite  out  1 each  APB control
- tim_paddr  out  ADDR_W; tim_pwdata  out  DATA_W; tim_pstrb  out  STRB_W
- tim_pready, tim_pslverr  in  1 each; tim_prdata  in  DATA_W

## Operation
- FSM states: IDLE, SETUP, ACCESS.
- IDLE: cmd_ready = 1. On handshake, latch write, addr, wdata and strb, then go to SETUP. Strb is latched as 0 when cmd_write = 0.
- SETUP: psel = 1, penable = 0, address, control and data driven from the latches. Always moves to ACCESS after one cycle.
- ACCESS: psel = 1, penable = 1.
  - If pready = 1: sample prdata (reads only) and pslverr, go to IDLE, and pulse rsp_valid next cycle.
  - If pready = 0: increment the wait counter. When the counter equals TIMEOUT_CYC (and TIMEOUT_CYC ≠ 0), deassert psel/penable, go to IDLE, and respond with rsp_err = 1, rsp_timeout = 1, rsp_rdata = 0.
- Wait counter is cleared on entry to SETUP. Its width is clog2(TIMEOUT_CYC+1) and it saturates, never wraps.
- paddr, pwrite, pwdata and pstrb are stable from SETUP through the final ACCESS cycle. All are 0 in IDLE.
- cmd_ready is 0 in SETUP and ACCESS. No command queuing: exactly one outstanding transfer.
- Write responses: rsp_rdata = 0, rsp_err = the sampled pslverr.

## Timing
- All outputs are registered.
- Reset values: state IDLE, cmd_ready = 1, rsp_valid = 0, rsp_rdata = 0, rsp_err = 0, rsp_timeout = 0, every APB output = 0.
- Zero-wait transfer: handshake at cycle N, SETUP at N+1, ACCESS at N+2, rsp_valid and cmd_ready = 1 at N+3. Back-to-back throughput is one transfer per 3 cycles.
- Each wait state adds 1 cycle.
- Timeout: ACCESS lasts exactly TIMEOUT_CYC cycles, then psel = 0 and rsp_valid on the next cycle.
- rsp_valid is high for exactly one cycle. rsp_rdata, rsp_err and rsp_timeout hold their values until the next response.
- pready = 1 in the same cycle the counter hits TIMEOUT_CYC: completion wins, normal response, rsp_timeout = 0.
- pready and pslverr are ignored outside ACCESS.
- sys_rst asserted mid-transfer: next edge returns all outputs to reset values. No response is issued for the aborted command.
- Command inputs are don't-care unless cmd_valid & cmd_ready.

## Structure
- Shared package tim_apb_pkg:
  - state enum (IDLE/SETUP/ACCESS)
  - ADDR_W/DATA_W defaults
  - timer register address constants (used by the test plan and the self-test sequencer)
- One natural sub-module: tim_apb_wdog, the saturating wait counter with clear, enable and expired output. The FSM, latches and response register stay in the top.

## Test plan
- Write 0xDEADBEEF to addr 0x004, strb 0xF, slave pready = 1: psel rises at N+1, penable at N+2, rsp_valid at N+3 with rsp_err = 0 and rsp_rdata = 0; paddr/pwdata stable across both APB cycles.
- Read addr 0x008 with 3 wait states, prdata = 0x12345678 on the pready cycle: rsp_valid at N+6 with rsp_rdata = 0x12345678; pstrb = 0 throughout.
- Write with pslverr = 1 at pready: rsp_err = 1, rsp_timeout = 0; next command is accepted at the rsp_valid cycle.
- TIMEOUT_CYC = 4, pready held 0: penable high for exactly 4 cycles, then psel = 0 and rsp_err = rsp_timeout = 1, rsp_rdata = 0. Repeat with pready rising on the 4th cycle: normal response, rsp_timeout = 0.
- sys_rst pulsed during ACCESS: next cycle all APB outputs are 0, cmd_ready = 1, no rsp_valid. A following read to 0x000 completes normally.
- Back-to-back: 8 commands with cmd_valid held high, zero-wait slave: handshakes every 3 cycles, 8 rsp_valid pulses, addresses in order.
